// File: rtl/cnu_min_sched.sv
// Serial check-node min finder: one V2C magnitude per cycle, tracks min1/min2/index
// per degree-6 or degree-8 row and emits one result per row through a single-entry register.
module cnu_min_sched #(
    parameter int QUAN_SIZE = 4,
    parameter int ROW_W     = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cfg_deg6,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE-1:0] out_min1,
    output logic [QUAN_SIZE-1:0] out_min2,
    output logic [2:0]           out_min_index,
    output logic                 out_deg6,
    output logic [ROW_W-1:0]     out_row_id,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2:0]           cnt_r;
    logic                 deg6_r;
    logic [QUAN_SIZE-1:0] min1_r;
    logic [QUAN_SIZE-1:0] min2_r;
    logic [2:0]           idx_r;

    logic                 hs_s;
    logic                 last_slot_s;
    logic                 out_hs_s;
    logic [QUAN_SIZE-1:0] min1_nxt_s;
    logic [QUAN_SIZE-1:0] min2_nxt_s;
    logic [2:0]           idx_nxt_s;

    assign hs_s        = in_valid && in_ready;
    assign out_hs_s    = out_valid && out_ready;
    assign last_slot_s = (state_r == ACCUM) && (cnt_r == (deg6_r ? 3'd5 : 3'd7));

    // State register of the row accumulator
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a row opens on its first handshake and closes on the last-slot handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (hs_s && last_slot_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: only the final message of a row can stall behind an unconsumed result
    always_comb begin
        in_ready = 1'b1;
        busy     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ACCUM: begin
                in_ready = !(last_slot_s && out_valid && !out_ready);
                busy     = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
        endcase
    end

    // Shared comparator: strict less-than so ties never move the index
    always_comb begin
        min1_nxt_s = min1_r;
        min2_nxt_s = min2_r;
        idx_nxt_s  = idx_r;
        if (state_r == IDLE) begin
            min1_nxt_s = in_msg;
            min2_nxt_s = {QUAN_SIZE{1'b1}};
            idx_nxt_s  = 3'd0;
        end else if (in_msg < min1_r) begin
            min1_nxt_s = in_msg;
            min2_nxt_s = min1_r;
            idx_nxt_s  = cnt_r;
        end else if (in_msg < min2_r) begin
            min2_nxt_s = in_msg;
        end else begin
            min2_nxt_s = min2_r;
        end
    end

    // Running row state, advanced only on an input handshake
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 3'd0;
            deg6_r <= 1'b0;
            min1_r <= {QUAN_SIZE{1'b0}};
            min2_r <= {QUAN_SIZE{1'b0}};
            idx_r  <= 3'd0;
        end else if (hs_s) begin
            if (state_r == IDLE) begin
                deg6_r <= cfg_deg6;
            end else begin
                deg6_r <= deg6_r;
            end
            cnt_r  <= last_slot_s ? 3'd0 : cnt_r + 3'd1;
            min1_r <= min1_nxt_s;
            min2_r <= min2_nxt_s;
            idx_r  <= idx_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Single-entry result register; a new load wins over a same-cycle consume
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_min1      <= {QUAN_SIZE{1'b0}};
            out_min2      <= {QUAN_SIZE{1'b0}};
            out_min_index <= 3'd0;
            out_deg6      <= 1'b0;
            out_row_id    <= {ROW_W{1'b0}};
        end else begin
            if (hs_s && last_slot_s) begin
                out_valid     <= 1'b1;
                out_min1      <= min1_nxt_s;
                out_min2      <= min2_nxt_s;
                out_min_index <= idx_nxt_s;
                out_deg6      <= deg6_r;
            end else if (out_hs_s) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
            if (out_hs_s) begin
                out_row_id <= out_row_id + {{(ROW_W-1){1'b0}}, 1'b1};
            end else begin
                out_row_id <= out_row_id;
            end
        end
    end

endmodule

// File: tb/tb_cnu_min_sched.sv
// Directed bench for cnu_min_sched: row expectations come from a reference min search
// and are queued at stimulus time, then popped when a result is handed off.
module tb_cnu_min_sched;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_deg6 = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_msg = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_min1;
    logic [3:0] out_min2;
    logic [2:0] out_min_index;
    logic       out_deg6;
    logic [7:0] out_row_id;
    logic       busy;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m2;
        logic [2:0] idx;
        logic       d6;
        logic [7:0] rid;
    } exp_t;

    exp_t       sb[$];
    exp_t       held;
    logic [7:0] exp_row = 8'd0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         ready_dropped = 1'b0;
    logic [3:0] r [8];

    cnu_min_sched #(.QUAN_SIZE(4), .ROW_W(8)) dut (
        .sys_clk(sys_clk), .rst(rst), .cfg_deg6(cfg_deg6),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min1(out_min1), .out_min2(out_min2), .out_min_index(out_min_index),
        .out_deg6(out_deg6), .out_row_id(out_row_id), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t row_model(input int deg, input logic [3:0] m [8]);
        exp_t e;
        e.idx = 3'd0;
        e.m1  = m[0];
        for (int i = 1; i < deg; i++) begin
            if (m[i] < e.m1) begin
                e.m1  = m[i];
                e.idx = 3'(i);
            end
        end
        e.m2 = 4'hF;
        for (int i = 0; i < deg; i++) begin
            if (i != int'(e.idx) && m[i] < e.m2) e.m2 = m[i];
        end
        e.d6  = (deg == 6);
        e.rid = 8'd0;
        return e;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive the first n_send messages of a row; queue its expectation when the row completes.
    task automatic send_row(input int deg, input logic [3:0] m [8], input int n_send, input int toggle_at);
        exp_t e;
        int   wait_cnt;
        for (int i = 0; i < n_send; i++) begin
            in_valid = 1'b1;
            in_msg   = m[i];
            cfg_deg6 = (deg == 6) ^ (i == toggle_at);
            if (i == deg - 1) begin
                e     = row_model(deg, m);
                e.rid = exp_row;
                exp_row++;
                sb.push_back(e);
            end
            #0;
            if (!in_ready) ready_dropped = 1'b1;
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            if (wait_cnt >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
            step();
        end
    endtask

    // Scoreboard: a result is handed off at the next rising edge when valid and ready are both high
    always @(negedge sys_clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_min1", 32'(out_min1), 32'(e.m1));
                chk("out_min2", 32'(out_min2), 32'(e.m2));
                chk("out_min_index", 32'(out_min_index), 32'(e.idx));
                chk("out_deg6", 32'(out_deg6), 32'(e.d6));
                chk("out_row_id", 32'(out_row_id), 32'(e.rid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_min1", 32'(out_min1), 32'd0);
        chk("rst_out_min2", 32'(out_min2), 32'd0);
        chk("rst_out_min_index", 32'(out_min_index), 32'd0);
        chk("rst_out_deg6", 32'(out_deg6), 32'd0);
        chk("rst_out_row_id", 32'(out_row_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Degree 8 basic row, one-cycle result latency
        r = '{4'd5, 4'd3, 4'd7, 4'd3, 4'd9, 4'd1, 4'd4, 4'd6};
        send_row(8, r, 8, -1);
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("busy_after_row", 32'(busy), 32'd0);
        step();

        // Degree 6 with tie at min1, then all-max degree 8
        r = '{4'd2, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd0};
        send_row(6, r, 6, -1);
        r = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        send_row(8, r, 8, -1);
        in_valid = 1'b0;
        step();

        // Back-to-back rows, cfg_deg6 flipped mid-row must be ignored
        ready_dropped = 1'b0;
        r = '{4'd9, 4'd8, 4'd4, 4'd12, 4'd4, 4'd10, 4'd0, 4'd0};
        send_row(6, r, 6, 3);
        chk("b2b_valid_row1", 32'(out_valid), 32'd1);
        r = '{4'd7, 4'd11, 4'd6, 4'd13, 4'd14, 4'd3, 4'd8, 4'd3};
        send_row(8, r, 8, -1);
        chk("b2b_valid_row2", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        chk("b2b_in_ready_steady", 32'(ready_dropped), 32'd0);
        step();

        // Backpressure: second row's last message stalls until the first result is taken
        out_ready = 1'b0;
        r = '{4'd6, 4'd4, 4'd9, 4'd1, 4'd7, 4'd3, 4'd0, 4'd0};
        send_row(6, r, 6, -1);
        held = sb[0];
        r = '{4'd8, 4'd2, 4'd10, 4'd5, 4'd12, 4'd0, 4'd0, 4'd0};
        send_row(6, r, 5, -1);
        in_valid = 1'b1;
        in_msg   = r[5];
        cfg_deg6 = 1'b1;
        sb.push_back('{m1: 4'd0, m2: 4'd2, idx: 3'd5, d6: 1'b1, rid: exp_row});
        exp_row++;
        for (int i = 0; i < 3; i++) begin
            #0;
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_held_min1", 32'(out_min1), 32'(held.m1));
            chk("bp_held_min2", 32'(out_min2), 32'(held.m2));
            chk("bp_held_idx", 32'(out_min_index), 32'(held.idx));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        chk("bp_row2_loaded", 32'(out_valid), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset mid-row with a pending result
        out_ready = 1'b0;
        r = '{4'd3, 4'd5, 4'd1, 4'd9, 4'd2, 4'd4, 4'd0, 4'd0};
        send_row(6, r, 6, -1);
        r = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        send_row(8, r, 3, -1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        sb.delete();
        exp_row = 8'd0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_row_id", 32'(out_row_id), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        r = '{4'd9, 4'd4, 4'd12, 4'd4, 4'd0, 4'd7, 4'd0, 4'd5};
        send_row(8, r, 8, -1);
        in_valid = 1'b0;
        step();

        // Random rows with random degree
        for (int k = 0; k < 6; k++) begin
            int deg;
            deg = ($urandom_range(0, 1) == 0) ? 6 : 8;
            for (int i = 0; i < 8; i++) r[i] = 4'($urandom_range(0, 15));
            send_row(deg, r, deg, -1);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
